// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters:
//   r0 - pipeline execute stage
//   r1 - address/branch unit
// Each requester issues one operation through a valid/ready request channel.
// The arbiter grants one requester and latches its operands into the ALU drive
// registers. It lets the ALU evaluate for one cycle, then registers the result.
// The result goes back on the owner's response channel until the owner takes it.
// Only one operation is in flight at a time.
// The sequence is IDLE -> EXEC -> RESP -> IDLE.
//
// Arbitration when both requesters are valid in IDLE:
//   default                  round-robin; the pointer moves to the requester
//                            that did not own the op just completed, so r1
//                            cannot starve under a continuous r0 stream.
//   ALU_ARB_FIXED_PRIO_EN    r0 always wins; the round-robin pointer is
//                            ignored.
//
// Parameters
//   DATA_W  operand/result width
//   OP_W    ALU op selector width
//   SH_W    shift amount width
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high
//   rN_req_valid/ready              request handshake (ready is combinational,
//                                   only in IDLE, only for the winner)
//   rN_req_op/shamt/a/b             request payload
//   rN_resp_valid/ready             response handshake
//   rN_resp_data/zero               registered result and result==0 flag
//   alu_op/alu_shamt/alu_in1/in2    registered drive to the ALU
//   alu_out/alu_zero                ALU result inputs
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int SH_W   = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic [OP_W-1:0]   r0_req_op,
    input  logic [SH_W-1:0]   r0_req_shamt,
    input  logic [DATA_W-1:0] r0_req_a,
    input  logic [DATA_W-1:0] r0_req_b,
    output logic              r0_resp_valid,
    input  logic              r0_resp_ready,
    output logic [DATA_W-1:0] r0_resp_data,
    output logic              r0_resp_zero,

    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic [OP_W-1:0]   r1_req_op,
    input  logic [SH_W-1:0]   r1_req_shamt,
    input  logic [DATA_W-1:0] r1_req_a,
    input  logic [DATA_W-1:0] r1_req_b,
    output logic              r1_resp_valid,
    input  logic              r1_resp_ready,
    output logic [DATA_W-1:0] r1_resp_data,
    output logic              r1_resp_zero,

    output logic [OP_W-1:0]   alu_op,
    output logic [SH_W-1:0]   alu_shamt,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state;

    // Requester preferred on a tie: 0 = r0, 1 = r1.
    logic rr_ptr;
    // Requester that owns the op in flight.
    logic owner;

    // ALU drive registers.
    logic [OP_W-1:0]   op_p0;
    logic [SH_W-1:0]   shamt_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;

    // Result registers and per-requester response valid.
    logic [DATA_W-1:0] res_data_p1;
    logic              res_zero_p1;
    logic [1:0]        vld_p1;

    logic              winner;
    logic              in_idle;
    logic              accept;
    logic              resp_take;
    logic [OP_W-1:0]   sel_op;
    logic [SH_W-1:0]   sel_shamt;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // Winner index: the sole valid requester, or the tie-break choice when
    // both are valid. The result is meaningless when neither is valid, and
    // ready is gated by valid in that case.
    function automatic logic pick_winner(input logic v0, input logic v1,
                                         input logic ptr);
        logic tie_sel;
        tie_sel = FIXED_PRIO ? 1'b0 : ptr;
        return (v0 && v1) ? tie_sel : v1;
    endfunction

    always_comb begin
        winner    = pick_winner(r0_req_valid, r1_req_valid, rr_ptr);
        in_idle   = (state == ST_IDLE) && !reset;
        r0_req_ready = in_idle && r0_req_valid && !winner;
        r1_req_ready = in_idle && r1_req_valid &&  winner;
        accept    = r0_req_ready || r1_req_ready;
        resp_take = (vld_p1[0] && r0_resp_ready) || (vld_p1[1] && r1_resp_ready);

        sel_op    = winner ? r1_req_op    : r0_req_op;
        sel_shamt = winner ? r1_req_shamt : r0_req_shamt;
        sel_a     = winner ? r1_req_a     : r0_req_a;
        sel_b     = winner ? r1_req_b     : r0_req_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            op_p0       <= '0;
            shamt_p0    <= '0;
            a_p0        <= '0;
            b_p0        <= '0;
            res_data_p1 <= '0;
            res_zero_p1 <= 1'b0;
            vld_p1      <= 2'b00;
        end else begin
            case (state)
                // Stage p0: latch the winner's payload into the ALU drive regs.
                // The regs hold their value in every other state so the ALU
                // inputs do not toggle while the arbiter is idle.
                ST_IDLE: begin
                    if (accept) begin
                        op_p0    <= sel_op;
                        shamt_p0 <= sel_shamt;
                        a_p0     <= sel_a;
                        b_p0     <= sel_b;
                        owner    <= winner;
                        state    <= ST_EXEC;
                    end
                end
                // Stage p1: capture the ALU result after one cycle of evaluation.
                ST_EXEC: begin
                    res_data_p1 <= alu_out;
                    res_zero_p1 <= alu_zero;
                    vld_p1      <= owner ? 2'b10 : 2'b01;
                    state       <= ST_RESP;
                end
                // Hold the response until the owner takes it. Then hand the
                // tie-break to the other requester.
                ST_RESP: begin
                    if (resp_take) begin
                        vld_p1 <= 2'b00;
                        rr_ptr <= ~owner;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    vld_p1 <= 2'b00;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_op        = op_p0;
    assign alu_shamt     = shamt_p0;
    assign alu_in1       = a_p0;
    assign alu_in2       = b_p0;

    // Both response channels share the result registers. Only the owner's
    // valid is ever asserted.
    assign r0_resp_valid = vld_p1[0];
    assign r1_resp_valid = vld_p1[1];
    assign r0_resp_data  = res_data_p1;
    assign r1_resp_data  = res_data_p1;
    assign r0_resp_zero  = res_zero_p1;
    assign r1_resp_zero  = res_zero_p1;

endmodule
